shift_add_multiplier: RTL and testbench
=======================================

# shift_add_multiplier

Parametrised signed shift-add multiplier for the board-level lab designs. Multiplies a WIDTH-bit two's-complement multiplicand from the slider switches by a WIDTH-bit multiplier held in register B, producing a 2·WIDTH-bit signed product in the A:B register pair, with sign bit X.
- Generalises the fixed-width add/shift datapath to any WIDTH.
- Multiplicand is latched at start, so switch changes cannot corrupt a run in progress.
- Run is handshaked, so each button press yields exactly one multiplication.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥ 2.
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- ClearA_LoadB  in  1  active-low; loads B from SW and clears A, X.
- Run  in  1  active-low; starts a multiplication.
- SW  in  WIDTH  multiplicand source (S) and B load value.
- Aval  out  WIDTH  register A (product high half when done).
- Bval  out  WIDTH  register B (product low half when done).
- X  out  1  sign-extension bit of A.
- Busy  out  1  high while a multiplication is in progress.
- Done  out  1  high once a multiplication has completed.

Notes:
- All outputs are registered.
- Run and ClearA_LoadB arrive already synchronised to Clk.

## Operation
- **Internal state:** multiplicand register M (WIDTH bits); iteration counter CNT ($clog2(WIDTH) bits).
- **FSM states:** IDLE, ADD, SHIFT, HOLD.
- **Reset:** A=0, B=0, X=0, M=0, CNT=0, Busy=0, Done=0, state=IDLE.
- **IDLE:**
  - If ClearA_LoadB=0: B<=SW, A<=0, X<=0, Done<=0. ClearA_LoadB has priority over Run, so no start occurs on that edge.
  - Else if Run=0 (start): M<=SW, A<=0, X<=0, CNT<=0, Done<=0, Busy<=1, go to ADD.
  - B is not cleared on start, so the previous low product half serves as the next multiplier (chained multiply).
- **ADD:**
  - If B[0]=1: compute the (WIDTH+1)-bit sum {A[W-1],A} ± {M[W-1],M}.
    - Subtract when CNT = WIDTH-1; add otherwise.
    - A <= sum[W-1:0]; X <= sum[W].
  - If B[0]=0: A is unchanged, and X <= A[W-1].
  - Go to SHIFT.
- **SHIFT:**
  - Arithmetic right shift of {X,A,B} by 1: X keeps its value, A[W-1]<=X, B[W-1]<=A[0].
  - If CNT = WIDTH-1: Busy<=0, Done<=1, go to HOLD.
  - Otherwise: CNT<=CNT+1, go to ADD.
- **HOLD:**
  - Stay while Run=0.
  - On Run=1, go to IDLE; Done stays 1.
  - ClearA_LoadB=0 in HOLD acts as in IDLE, including clearing Done.
- **While busy:** Run and ClearA_LoadB are ignored in ADD and SHIFT. SW changes have no effect because M is latched.
- **Result:** {X,A,B} is the (2·WIDTH+1)-bit signed product; {A,B} equals it exactly for all operand pairs, including (-2^(W-1))·(-2^(W-1)).
- **Async reset mid-run:** aborts immediately to the reset values; no partial result is retained.

## Timing
- Start edge t0 (IDLE with Run=0 sampled): Busy=1 after t0.
- ADD occupies the cycles after t0, t2, …; SHIFT occupies the cycles after t1, t3, … (one ADD/SHIFT pair per iteration).
- The final SHIFT is at edge t(2·WIDTH). After that edge: product valid, Busy=0, Done=1. Latency is 2·WIDTH+1 edges including the start edge (17 for WIDTH=8).
- A Run held low through completion does not restart; release plus a fresh press is required. Minimum one cycle high in HOLD, then one cycle low in IDLE.
- ClearA_LoadB takes effect on the sampling edge; Bval updates one cycle later.

## Test plan
- **Reset:** Reset low mid-run at CNT=3 → all outputs 0 immediately (asynchronous), state IDLE; Run is then ignored until Reset=1.
- **Positive × positive (WIDTH=8):**
  - Stimulus: ClearA_LoadB with SW=0x3B, then Run with SW=0x07, toggling SW during the run.
  - Response after 17 edges: Aval=0x01, Bval=0x9D, X=0, Done=1; Busy high for exactly 16 cycles.
- **Negative multiplicand:** B=0x03, S=0xFE → Aval=0xFF, Bval=0xFA, X=1 (-6).
- **Negative multiplier (final subtract):** B=0x80, S=0x80 → Aval=0x40, Bval=0x00, X=0 (+16384).
- **Handshake and chaining:**
  - After the 0x07·0x3B result, hold Run low for 50 cycles → exactly one multiplication.
  - Release Run, press again with SW=0x02 → multiplies B=0x9D (-99) by 2: Aval=0xFF, Bval=0x3A, X=1 (-198).
  - ClearA_LoadB and Run low together in IDLE → B loaded, no start.
- **Parameter sweep:** WIDTH=4 and WIDTH=12, exhaustive and random operand pairs against a signed reference model → {X,A,B} matches the sign-extended product; latency is 2·WIDTH+1 edges.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//
// Signed shift-add multiplier. A WIDTH-bit two's-complement multiplicand
// (sampled from SW at start) is multiplied by the WIDTH-bit multiplier held
// in register B. The 2*WIDTH-bit product is left in A:B, and X holds its sign.
// Each iteration spends one cycle in ADD and one cycle in SHIFT. The last
// iteration subtracts the multiplicand because the top multiplier bit has
// negative weight.
//
// Ports
//   Clk           system clock
//   Reset         asynchronous, active-low reset
//   ClearA_LoadB  active-low; loads B from SW and clears A, X, Done (IDLE/HOLD)
//   Run           active-low; starts one multiplication (IDLE only)
//   SW            multiplicand source and B load value
//   Aval          register A (product high half when done)
//   Bval          register B (product low half when done)
//   X             sign-extension bit of A
//   Busy          high while a multiplication is in progress
//   Done          high once a multiplication has completed
//   state_dbg     current FSM state (0 IDLE, 1 ADD, 2 SHIFT, 3 HOLD)
//
// Handshake: a start is accepted only in IDLE. After completion the FSM waits
// in HOLD until Run is released, so one press gives exactly one
// multiplication. Run and ClearA_LoadB are ignored in ADD and SHIFT.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    cnt;

  // One extra bit is kept so that X captures the true sign of the partial
  // sum. Without it, (-2^(W-1)) * (-2^(W-1)) would overflow.
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  always_comb begin
    a_ext = {Aval[WIDTH-1], Aval};
    m_ext = {m[WIDTH-1], m};
    sum   = (cnt == LAST) ? (a_ext - m_ext) : (a_ext + m_ext);
  end

  assign state_dbg = state;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      Aval  <= '0;
      Bval  <= '0;
      X     <= 1'b0;
      m     <= '0;
      cnt   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!ClearA_LoadB) begin
            Bval <= SW;
            Aval <= '0;
            X    <= 1'b0;
            Done <= 1'b0;
          end else if (!Run) begin
            // B is left alone so the previous low half can be chained in.
            m     <= SW;
            Aval  <= '0;
            X     <= 1'b0;
            cnt   <= '0;
            Done  <= 1'b0;
            Busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          if (Bval[0]) begin
            Aval <= sum[WIDTH-1:0];
            X    <= sum[WIDTH];
          end else begin
            X <= Aval[WIDTH-1];
          end
          state <= SHIFT;
        end
        SHIFT: begin
          Aval <= {X, Aval[WIDTH-1:1]};
          Bval <= {Aval[0], Bval[WIDTH-1:1]};
          if (cnt == LAST) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= HOLD;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ADD;
          end
        end
        HOLD: begin
          if (!ClearA_LoadB) begin
            Bval <= SW;
            Aval <= '0;
            X    <= 1'b0;
            Done <= 1'b0;
          end
          // Run must be released before another start can be accepted.
          if (Run) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- WIDTH=8 instance ----------------
  logic        clr8 = 1'b1, run8 = 1'b1;
  logic [7:0]  sw8 = '0, aval8, bval8;
  logic        x8, busy8, done8;
  logic [1:0]  st8;

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(reset_n), .ClearA_LoadB(clr8), .Run(run8), .SW(sw8),
    .Aval(aval8), .Bval(bval8), .X(x8), .Busy(busy8), .Done(done8),
    .state_dbg(st8)
  );

  // ---------------- WIDTH=4 instance ----------------
  logic        clr4 = 1'b1, run4 = 1'b1;
  logic [3:0]  sw4 = '0, aval4, bval4;
  logic        x4, busy4, done4;
  logic [1:0]  st4;

  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .Clk(clk), .Reset(reset_n), .ClearA_LoadB(clr4), .Run(run4), .SW(sw4),
    .Aval(aval4), .Bval(bval4), .X(x4), .Busy(busy4), .Done(done4),
    .state_dbg(st4)
  );

  // ---------------- WIDTH=12 instance ----------------
  logic        clr12 = 1'b1, run12 = 1'b1;
  logic [11:0] sw12 = '0, aval12, bval12;
  logic        x12, busy12, done12;
  logic [1:0]  st12;

  shift_add_multiplier #(.WIDTH(12)) dut12 (
    .Clk(clk), .Reset(reset_n), .ClearA_LoadB(clr12), .Run(run12), .SW(sw12),
    .Aval(aval12), .Bval(bval12), .X(x12), .Busy(busy12), .Done(done12),
    .state_dbg(st12)
  );

  // Scoreboard queue of expected 16-bit products for the random W8 test.
  logic [15:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic load_b8(input logic [7:0] v);
    @(negedge clk); sw8 = v; clr8 = 1'b0;
    @(negedge clk); clr8 = 1'b1;
  endtask

  // Press Run with multiplicand s, scramble SW while busy, wait for Done.
  // Optionally keep Run low for 'hold' more cycles, then release it.
  task automatic do_mult8(input logic [7:0] s, input int hold,
                          output logic [15:0] prod, output logic xo,
                          output int busy_cyc, output int lat,
                          output logic timed_out, output logic hold_bad);
    @(negedge clk); sw8 = s; run8 = 1'b0;
    busy_cyc = 0; lat = 0; hold_bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (busy8) busy_cyc++;
      sw8 = 8'($urandom);
    end while (!done8 && lat < 100);
    timed_out = !done8;
    prod = {aval8, bval8};
    xo = x8;
    repeat (hold) begin
      @(negedge clk);
      if (busy8 || {aval8, bval8} !== prod || !done8) hold_bad = 1'b1;
    end
    run8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_mult4(input logic [3:0] b, input logic [3:0] s,
                          output logic [8:0] res, output int lat);
    @(negedge clk); sw4 = b; clr4 = 1'b0;
    @(negedge clk); clr4 = 1'b1; sw4 = s; run4 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!done4 && lat < 100);
    res = {x4, aval4, bval4};
    run4 = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_mult12(input logic [11:0] b, input logic [11:0] s,
                           output logic [24:0] res, output int lat);
    @(negedge clk); sw12 = b; clr12 = 1'b0;
    @(negedge clk); clr12 = 1'b1; sw12 = s; run12 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!done12 && lat < 100);
    res = {x12, aval12, bval12};
    run12 = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [7:0] a_mid, b_mid;
    // Reset state (reset asserted since time 0).
    @(negedge clk);
    checks++;
    if ({aval8, bval8, x8, busy8, done8, st8} !== 21'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", {aval8, bval8, x8, busy8, done8, st8});
    end
    reset_n = 1'b1;
    load_b8(8'h3B);
    @(negedge clk); sw8 = 8'h07; run8 = 1'b0;
    // Seven edges after the start edge: in ADD with CNT=3.
    repeat (7) @(negedge clk);
    a_mid = aval8; b_mid = bval8;
    checks++;
    if (busy8 !== 1'b1) begin
      failures++;
      $display("FAIL reset_midrun_busy got=%b exp=1", busy8);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({aval8, bval8, x8, busy8, done8, st8} !== 21'd0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0 (before a=%h b=%h)",
               {aval8, bval8, x8, busy8, done8, st8}, a_mid, b_mid);
    end
    // Run still low while reset held: nothing may start.
    repeat (3) @(negedge clk);
    checks++;
    if ({busy8, st8} !== 3'd0) begin
      failures++;
      $display("FAIL reset_run_ignored got=%b exp=0", {busy8, st8});
    end
    run8 = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pos_pos;
    logic [15:0] p; logic xo; int bc, lat; logic to, hb;
    load_b8(8'h3B);
    checks++;
    if (bval8 !== 8'h3B) begin
      failures++;
      $display("FAIL load_b got=%h exp=3b", bval8);
    end
    do_mult8(8'h07, 50, p, xo, bc, lat, to, hb);
    checks++;
    if (to || {xo, p} !== {1'b0, 16'h019D}) begin
      failures++;
      $display("FAIL pos_pos got=%b_%h exp=0_019d timeout=%b", xo, p, to);
    end
    checks++;
    if (bc !== 16 || lat !== 17) begin
      failures++;
      $display("FAIL pos_pos_timing busy=%0d lat=%0d exp busy=16 lat=17", bc, lat);
    end
    checks++;
    if (hb !== 1'b0) begin
      failures++;
      $display("FAIL run_held_restart got=%b exp=0", hb);
    end
  endtask

  task automatic test_chain;
    logic [15:0] p; logic xo; int bc, lat; logic to, hb;
    // B still holds 0x9D (-99) from the previous product.
    do_mult8(8'h02, 0, p, xo, bc, lat, to, hb);
    checks++;
    if (to || {xo, p} !== {1'b1, 16'hFF3A}) begin
      failures++;
      $display("FAIL chain got=%b_%h exp=1_ff3a", xo, p);
    end
  endtask

  task automatic test_neg_operands;
    logic [15:0] p; logic xo; int bc, lat; logic to, hb;
    load_b8(8'h03);
    do_mult8(8'hFE, 0, p, xo, bc, lat, to, hb);
    checks++;
    if (to || {xo, p} !== {1'b1, 16'hFFFA}) begin
      failures++;
      $display("FAIL neg_mcand got=%b_%h exp=1_fffa", xo, p);
    end
    load_b8(8'h80);
    do_mult8(8'h80, 0, p, xo, bc, lat, to, hb);
    checks++;
    if (to || {xo, p} !== {1'b0, 16'h4000}) begin
      failures++;
      $display("FAIL min_x_min got=%b_%h exp=0_4000", xo, p);
    end
  endtask

  task automatic test_clear_priority;
    logic bad;
    @(negedge clk); sw8 = 8'h55; clr8 = 1'b0; run8 = 1'b0;
    @(negedge clk); clr8 = 1'b1; run8 = 1'b1;
    checks++;
    if ({bval8, aval8, x8, busy8, done8} !== {8'h55, 8'h00, 3'b000}) begin
      failures++;
      $display("FAIL clear_priority got=%h exp=55_00_0", {bval8, aval8, x8, busy8, done8});
    end
    bad = 1'b0;
    repeat (3) begin @(negedge clk); if (busy8 || st8 != 2'd0) bad = 1'b1; end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL clear_no_start got=%b exp=0", bad);
    end
  endtask

  task automatic test_random_w8;
    logic [7:0] b, s; logic [15:0] p, e; logic xo; int bc, lat; logic to, hb;
    logic signed [16:0] full;
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom_range(0, 255));
      s = 8'($urandom_range(0, 255));
      full = $signed(b) * $signed(s);
      exp_q.push_back(full[15:0]);
      load_b8(b);
      do_mult8(s, 0, p, xo, bc, lat, to, hb);
      e = exp_q.pop_front();
      checks++;
      if (to || p !== e || xo !== full[16] || lat !== 17) begin
        failures++;
        $display("FAIL rand_w8 b=%h s=%h got=%b_%h lat=%0d exp=%b_%h lat=17",
                 b, s, xo, p, lat, full[16], e);
      end
    end
  endtask

  task automatic test_sweep_w4;
    logic [8:0] r; logic signed [8:0] e; int lat; int bad;
    logic [3:0] b, s;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        b = 4'(i); s = 4'(j);
        e = $signed(b) * $signed(s);
        do_mult4(b, s, r, lat);
        checks++;
        if (r !== e || lat !== 9) begin
          failures++;
          bad++;
          if (bad < 10)
            $display("FAIL sweep_w4 b=%h s=%h got=%h lat=%0d exp=%h lat=9", b, s, r, lat, e);
        end
      end
    end
  endtask

  task automatic test_sweep_w12;
    logic [24:0] r; logic signed [24:0] e; int lat;
    logic [11:0] b, s;
    logic [11:0] corners [4];
    corners[0] = 12'h800; corners[1] = 12'h7FF; corners[2] = 12'hFFF; corners[3] = 12'h001;
    for (int i = 0; i < 40; i++) begin
      if (i < 16) begin
        b = corners[i % 4]; s = corners[i / 4];
      end else begin
        b = 12'($urandom); s = 12'($urandom);
      end
      e = $signed(b) * $signed(s);
      do_mult12(b, s, r, lat);
      checks++;
      if (r !== e || lat !== 25) begin
        failures++;
        $display("FAIL sweep_w12 b=%h s=%h got=%h lat=%0d exp=%h lat=25", b, s, r, lat, e);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset;
    test_pos_pos;
    test_chain;
    test_neg_operands;
    test_clear_priority;
    test_random_w8;
    test_sweep_w4;
    test_sweep_w12;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
